// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs burst command plus data beats into {data, addr} FIFO write words
module fifo_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int ADDR_STEP  = 1,
    parameter int FIFO_WIDTH = DATA_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en,
    output logic [FIFO_WIDTH-1:0] fifo_data_o,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    remain_q;
    logic                    done_q;
    logic                    beat_acc;

    // Handshakes stay combinational so a full FIFO stalls the beat in the same cycle.
    assign cmd_ready   = (state_q == IDLE);
    assign wdata_ready = (state_q == BURST) && !fifo_full_i;
    assign beat_acc    = wdata_valid && wdata_ready;
    assign fifo_wr_en  = beat_acc;
    assign fifo_data_o = {wdata, addr_q};
    assign busy        = (state_q == BURST);
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (cmd_valid) begin
                    addr_q   <= cmd_addr;
                    remain_q <= cmd_len;
                    state_q  <= BURST;
                end
            end else if (beat_acc) begin
                addr_q <= addr_q + STEP;
                // remain_q counts beats still owed after this one; zero means last beat
                if (remain_q == '0) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end else begin
                    remain_q <= remain_q - ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - randomized and directed bench for fifo_word_packer against a burst-level model
module tb_fifo_word_packer;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int LW   = 8;
    localparam int STEP = 1;
    localparam int FW   = DW + AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdata_valid = 1'b0;
    logic          wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          fifo_full_i = 1'b0;
    logic          fifo_wr_en;
    logic [FW-1:0] fifo_data_o;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .ADDR_STEP(STEP), .FIFO_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .fifo_full_i(fifo_full_i), .fifo_wr_en(fifo_wr_en), .fifo_data_o(fifo_data_o),
        .busy(busy), .done(done)
    );

    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] wlog[$];
    int            done_cnt = 0;
    int            wr_while_full = 0;
    bit            b2b_seen = 1'b0;

    // Burst-level model: a burst is a base address plus a count of beats written so far.
    bit            busy_m = 1'b0;
    bit            done_m = 1'b0;
    bit            acc_m = 1'b0;
    logic [AW-1:0] base_m = '0;
    int            idx_m = 0;
    int            total_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input int i);
        return AW'((int'(base) + i * STEP) % (1 << AW));
    endfunction

    always @(negedge clk) begin : cmp
        logic exp_wr;
        logic exp_we;
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_wdata_ready", wdata_ready, 0);
            chk("rst_fifo_wr_en", fifo_wr_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            busy_m = 1'b0; done_m = 1'b0; acc_m = 1'b0; idx_m = 0; total_m = 0;
        end else begin
            exp_wr = busy_m && !fifo_full_i;
            exp_we = exp_wr && wdata_valid;
            chk("cmd_ready", cmd_ready, !busy_m);
            chk("wdata_ready", wdata_ready, exp_wr);
            chk("fifo_wr_en", fifo_wr_en, exp_we);
            chk("busy", busy, busy_m);
            chk("done", done, done_m);
            if (exp_we) chk("fifo_data_o", fifo_data_o, {wdata, beat_addr(base_m, idx_m)});
            if (fifo_wr_en) wlog.push_back(fifo_data_o);
            if (fifo_wr_en && fifo_full_i) wr_while_full++;
            if (done) done_cnt++;
            if (done && cmd_ready && cmd_valid) b2b_seen = 1'b1;
            done_m = 1'b0;
            acc_m  = exp_we;
            if (!busy_m) begin
                if (cmd_valid) begin
                    busy_m = 1'b1; base_m = cmd_addr; idx_m = 0; total_m = int'(cmd_len) + 1;
                end
            end else if (exp_we) begin
                idx_m++;
                if (idx_m == total_m) begin
                    busy_m = 1'b0; done_m = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
    endtask

    // full_mode: 0 never full, 1 toggle every other cycle, 2 random
    task automatic drive_beats(input logic [DW-1:0] dbase, input int full_mode, input bit rand_valid,
                               input int stop_after, input int limit, output int sent);
        int n = 0;
        sent = 0;
        while (1) begin
            wdata = dbase + DW'(sent);
            wdata_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (full_mode == 0)      fifo_full_i = 1'b0;
            else if (full_mode == 1) fifo_full_i = n[0];
            else                     fifo_full_i = ($urandom_range(0, 3) == 0);
            step();
            n++;
            if (acc_m) sent++;
            if (!busy_m || sent == stop_after) break;
            if (n >= limit) begin
                checks++; errors++;
                $display("FAIL burst_timeout cycles=%0d required_below=%0d", n, limit);
                break;
            end
        end
        wdata_valid = 1'b0;
        fifo_full_i = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] dbase, input logic [AW-1:0] abase, input int n);
        chk({name, "_count"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk({name, "_word"}, wlog[i], {dbase + DW'(i), beat_addr(abase, i)});
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sent;
        logic [FW-1:0] basic_exp [4];
        logic [AW-1:0] wrap_exp [4];
        logic [AW-1:0] ra;
        logic [LW-1:0] rl;
        logic [DW-1:0] rd;
        basic_exp[0] = {32'hA0, 8'h10};
        basic_exp[1] = {32'hA1, 8'h11};
        basic_exp[2] = {32'hA2, 8'h12};
        basic_exp[3] = {32'hA3, 8'h13};
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;

        // reset held with both request inputs active
        rst_n = 1'b0; cmd_valid = 1'b1; wdata_valid = 1'b1; cmd_addr = 8'h33; cmd_len = 8'h2;
        repeat (4) step();
        chk("lit_rst_cmd_ready", cmd_ready, 1);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_wr_en", fifo_wr_en, 0);
        cmd_valid = 1'b0; wdata_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // basic burst
        wlog.delete(); done_cnt = 0;
        start_cmd(8'h10, 8'd3);
        drive_beats(32'hA0, 0, 1'b0, -1, 100, sent);
        step(); step();
        chk("lit_basic_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("lit_basic_word", wlog[i], basic_exp[i]);
        chk("lit_basic_done", done_cnt, 1);

        // address wrap
        wlog.delete(); done_cnt = 0;
        start_cmd(8'hFE, 8'd3);
        drive_beats(32'h100, 0, 1'b0, -1, 100, sent);
        step(); step();
        chk("lit_wrap_count", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("lit_wrap_addr", wlog[i][AW-1:0], wrap_exp[i]);

        // backpressure
        wlog.delete(); done_cnt = 0; wr_while_full = 0;
        start_cmd(8'h30, 8'd7);
        drive_beats(32'h200, 1, 1'b1, -1, 200, sent);
        step(); step();
        check_log("bp", 32'h200, 8'h30, 8);
        chk("bp_done", done_cnt, 1);
        chk("bp_wr_while_full", wr_while_full, 0);

        // back-to-back commands: second held through first burst
        wlog.delete(); done_cnt = 0; b2b_seen = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 8'h50; cmd_len = 8'd2;
        step();
        cmd_addr = 8'h80; cmd_len = 8'd1;
        drive_beats(32'h300, 0, 1'b0, -1, 100, sent);
        step();
        cmd_valid = 1'b0;
        drive_beats(32'h400, 0, 1'b0, -1, 100, sent);
        step(); step();
        chk("b2b_count", wlog.size(), 5);
        if (wlog.size() == 5) begin
            chk("lit_b2b_first", wlog[0], {32'h300, 8'h50});
            chk("lit_b2b_second", wlog[3], {32'h400, 8'h80});
            chk("lit_b2b_last", wlog[4], {32'h401, 8'h81});
        end
        chk("b2b_accept_on_done", b2b_seen, 1);
        chk("b2b_done", done_cnt, 2);

        // reset mid-burst
        wlog.delete(); done_cnt = 0;
        start_cmd(8'h60, 8'd9);
        drive_beats(32'h500, 0, 1'b0, 4, 100, sent);
        rst_n = 1'b0; wdata_valid = 1'b1;
        repeat (3) step();
        rst_n = 1'b1; wdata_valid = 1'b0;
        step(); step();
        check_log("rst_mid", 32'h500, 8'h60, 4);
        chk("rst_mid_done", done_cnt, 0);
        chk("rst_mid_busy", busy, 0);
        wlog.delete();
        start_cmd(8'h70, 8'd1);
        drive_beats(32'h600, 0, 1'b0, -1, 100, sent);
        step(); step();
        check_log("post_rst", 32'h600, 8'h70, 2);

        // randomized bursts, including a maximum-length one
        for (int b = 0; b < 8; b++) begin
            wlog.delete(); done_cnt = 0; wr_while_full = 0;
            ra = AW'($urandom);
            rl = (b == 3) ? 8'hFF : LW'($urandom_range(0, 20));
            rd = DW'($urandom);
            wdata_valid = 1'b1;
            step(); step();
            wdata_valid = 1'b0;
            start_cmd(ra, rl);
            drive_beats(rd, 2, 1'b1, -1, 3000, sent);
            step(); step();
            check_log("rand", rd, ra, int'(rl) + 1);
            chk("rand_done", done_cnt, 1);
            chk("rand_wr_while_full", wr_while_full, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Write-side counterpart of the PMU FIFO word format: accepts a burst command (base address, length) plus a stream of data words, and generates FIFO write words packed as {data, addr} with the address auto-incremented per beat. Sits between the PMU command source and the configuration FIFO. The FIFO's read side splits each word back into address and data. Throttles on FIFO full and signals burst completion.

## Interface
- DATA_WIDTH, 32, width of one data word
- ADDR_WIDTH, 8, width of the target address
- LEN_WIDTH, 8, width of the burst-length field (burst = cmd_len+1 beats)
- ADDR_STEP, 1, address increment per beat (modulo 2^ADDR_WIDTH)
- FIFO_WIDTH, DATA_WIDTH+ADDR_WIDTH, FIFO word width

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  burst command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  ADDR_WIDTH  base address of burst
- cmd_len  in  LEN_WIDTH  beats minus one
- wdata_valid  in  1  data beat present
- wdata_ready  out  1  beat accepted when wdata_valid & wdata_ready
- wdata  in  DATA_WIDTH  data beat
- fifo_full_i  in  1  FIFO cannot take a write this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_data_o  out  FIFO_WIDTH  {data in [FIFO_WIDTH-1:ADDR_WIDTH], addr in [ADDR_WIDTH-1:0]}
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after last beat written

## Operation
- FSM states: IDLE, BURST. Reset -> IDLE.
- IDLE: cmd_ready=1, wdata_ready=0. On cmd_valid: latch addr_q<=cmd_addr, remain_q<=cmd_len; go BURST.
- BURST: cmd_ready=0; wdata_ready = !fifo_full_i. Beat accepted (wdata_valid & wdata_ready):
  - fifo_wr_en=1 same cycle, fifo_data_o={wdata, addr_q} (combinational from wdata and registered addr_q).
  - addr_q <= addr_q + ADDR_STEP, truncated to ADDR_WIDTH (wraps 0xFF->0x00 at defaults).
  - remain_q==0: go IDLE, done<=1 next cycle; else remain_q <= remain_q-1.
- fifo_wr_en = wdata_valid & wdata_ready exactly; never asserted while fifo_full_i=1 or outside BURST.
- fifo_data_o is don't-care when fifo_wr_en=0; implement as the same combinational concatenation (no gating required).
- wdata_valid in IDLE is ignored (not consumed, no write).
- cmd_len all-ones: burst of 2^LEN_WIDTH beats; counter does not overflow (decrement only while nonzero).
- busy = (state==BURST).

## Timing
- Reset (async assert, sync release): state=IDLE, addr_q=0, remain_q=0, done=0; hence cmd_ready=1, wdata_ready=0, fifo_wr_en=0, busy=0.
- Command accepted cycle N -> busy=1 and wdata_ready eligible from cycle N+1.
- Data-to-FIFO latency: 0 cycles (write strobe same cycle as beat acceptance).
- Throughput: 1 beat/cycle while fifo_full_i=0 and wdata_valid=1.
- Last beat accepted cycle M -> cycle M+1: state=IDLE, busy=0, done=1, cmd_ready=1; a new command may be accepted in M+1 (done and acceptance coincide, legal).
- fifo_full_i rising mid-burst: wdata_ready drops the same cycle; no beat lost, addr_q/remain_q hold.
- wdata_valid low mid-burst: stall, state held indefinitely.
- rst_n asserted mid-burst: immediate abort to reset values; partially written beats remain in FIFO, no done pulse.

## Test plan
- Reset: hold rst_n=0 with cmd_valid=1, wdata_valid=1 -> cmd_ready=1, fifo_wr_en=0, busy=0, done=0 throughout.
- Basic burst: cmd_addr=0x10, cmd_len=3, data 0xA0..0xA3 back-to-back, fifo_full_i=0 -> 4 writes, fifo_data_o = {0xA0,0x10},{0xA1,0x11},{0xA2,0x12},{0xA3,0x13}; done pulses once the cycle after 4th write.
- Wrap: cmd_addr=0xFE, cmd_len=3 -> addresses 0xFE,0xFF,0x00,0x01.
- Backpressure: cmd_len=7, fifo_full_i toggled every other cycle and wdata_valid randomly deasserted -> exactly 8 writes, never with fifo_full_i=1, addresses contiguous, data order preserved.
- Back-to-back commands: second cmd_valid held during first burst -> accepted exactly in done cycle; second burst's first word uses its own cmd_addr.
- Reset mid-burst: cmd_len=9, assert rst_n=0 after 4 beats -> immediately IDLE, no further writes, no done; new command afterwards starts from its own base address.
